// File: rtl/pk_hasti.sv
// Shared HASTI (AHB-Lite) definitions for the SRAM slave slice.
// Contents: htrans/hsize/hresp encodings, the slave state enum and the
// little-endian byte-lane mask helper. No ports.
package pk_hasti;

    // htrans encodings; bit 1 set means an active (NONSEQ/SEQ) transfer.
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    // hsize encodings.
    localparam logic [2:0] SizeByte = 3'd0;
    localparam logic [2:0] SizeHalf = 3'd1;
    localparam logic [2:0] SizeWord = 3'd2;

    // hresp encodings.
    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } slave_state_e;

    // Byte lanes touched by a transfer. Halves use addr_lo[1] only and any
    // size above a half is treated as a full word, which is what forces
    // misaligned transfers onto aligned lanes.
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SizeByte: return 4'b0001 << addr_lo;
            SizeHalf: return 4'b0011 << {addr_lo[1], 1'b0};
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/hasti_sram_array.sv
// Word-organised SRAM storage for hasti_sram_slave.
// Ports:
//   hclk, hresetn       clock and asynchronous active-low reset (read register only)
//   re, raddr, rdata    synchronous read; rdata holds until the next re
//   we, waddr, wdata    per-byte write enable, write word index, write data
// A write and a read to the same word on one edge return the old contents.
module hasti_sram_array #(
    parameter int unsigned ADDR_WORDS_LOG2 = 8
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic                       re,
    input  logic [ADDR_WORDS_LOG2-1:0] raddr,
    output logic [31:0]                rdata,
    input  logic [3:0]                 we,
    input  logic [ADDR_WORDS_LOG2-1:0] waddr,
    input  logic [31:0]                wdata
);

    localparam int unsigned Depth = 1 << ADDR_WORDS_LOG2;

    logic [31:0] mem [Depth];
    logic [31:0] rdata_q;

    // Storage itself is not reset.
    always_ff @(posedge hclk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hasti_sram_slave.sv
// HASTI (AHB-Lite) slave in front of an on-chip word SRAM.
// Optional feature macro: HASTI_MISALIGN_ERR_EN -- when defined, misaligned
// or oversized transfers get a two-cycle ERROR response and touch nothing;
// when undefined they are forced aligned and hresp is always OKAY.
// Ports:
//   hclk, hresetn                 bus clock, asynchronous active-low reset
//   hsel, haddr, hwrite, hsize    address-phase controls from the decoder/master
//   hburst, hprot, hmastlock      accepted but ignored
//   htrans, hready                transfer type and looped-back bus ready
//   hwdata                        write data (data phase)
//   hreadyout, hrdata, hresp      slave ready, read data, response
module hasti_sram_slave
    import pk_hasti::*;
#(
    parameter int unsigned ADDR_WORDS_LOG2 = 8,
    parameter int unsigned WAIT_STATES     = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp
);

    localparam int unsigned AW = ADDR_WORDS_LOG2;
    localparam logic [2:0] WsLoad = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_e    state_q, state_d, launch_state;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   waddr_q;
    logic [3:0]      mask_q;
    logic            write_q;
    logic [3:0]      fwd_mask_q;
    logic [31:0]     fwd_data_q;

    logic            accept;
    logic            err_in;
    logic [AW-1:0]   idx_in;
    logic [3:0]      mask_in;
    logic            commit;
    logic            re;
    logic            fwd_hit;
    logic [3:0]      we;
    logic [31:0]     arr_rdata;

    logic unused_bits;
    assign unused_bits = ^{hburst, hprot, hmastlock, haddr[31:AW+2]};

    // hreadyout is folded in so a stalled data phase never takes a new address.
    assign accept  = hsel && hready && htrans[1] && hreadyout;
    assign idx_in  = haddr[AW+1:2];
    assign mask_in = byte_mask(hsize, haddr[1:0]);

`ifdef HASTI_MISALIGN_ERR_EN
    assign err_in = ((hsize == SizeHalf) && haddr[0])
                 || ((hsize == SizeWord) && (haddr[1:0] != 2'b00))
                 || (hsize > SizeWord);
`else
    assign err_in = 1'b0;
`endif

    // Write data is taken on the edge that closes the data phase.
    assign commit  = (state_q == StData) && write_q;
    assign we      = commit ? mask_q : 4'b0000;
    assign re      = accept && !hwrite && !err_in;
    assign fwd_hit = commit && (waddr_q == idx_in);

    hasti_sram_array #(
        .ADDR_WORDS_LOG2(AW)
    ) u_array (
        .hclk   (hclk),
        .hresetn(hresetn),
        .re     (re),
        .raddr  (idx_in),
        .rdata  (arr_rdata),
        .we     (we),
        .waddr  (waddr_q),
        .wdata  (hwdata)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            waddr_q    <= '0;
            mask_q     <= '0;
            write_q    <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                waddr_q <= idx_in;
                mask_q  <= mask_in;
                write_q <= hwrite && !err_in;
            end
            // The array returns pre-write data on a same-word collision, so
            // remember which lanes must come from the write instead.
            if (re) begin
                fwd_mask_q <= fwd_hit ? mask_q : 4'b0000;
                fwd_data_q <= hwdata;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        launch_state = StData;
        if (err_in) begin
            launch_state = StErr1;
        end else if (WAIT_STATES > 0) begin
            launch_state = StWait;
        end

        case (state_q)
            StIdle, StData: state_d = accept ? launch_state : StIdle;
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef HASTI_MISALIGN_ERR_EN
            StErr1: state_d = StErr2;
            StErr2: state_d = accept ? launch_state : StIdle;
`endif
            default: state_d = StIdle;
        endcase

        if (accept) begin
            cnt_d = WsLoad;
        end
    end

    always_comb begin
        hreadyout = !((state_q == StWait) || (state_q == StErr1));
`ifdef HASTI_MISALIGN_ERR_EN
        hresp = ((state_q == StErr1) || (state_q == StErr2)) ? HrespError : HrespOkay;
`else
        hresp = HrespOkay;
`endif
    end

    always_comb begin
        hrdata = '0;
        for (int i = 0; i < 4; i++) begin
            hrdata[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8] : arr_rdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Self-checking bench: two slaves (WAIT_STATES 0 and 3) against a byte-array model.
module tb_hasti_sram_slave;

`ifdef HASTI_MISALIGN_ERR_EN
    localparam bit ErrMode = 1'b1;
`else
    localparam bit ErrMode = 1'b0;
`endif

    logic        hclk;
    logic        hresetn   [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [1:0]  htrans    [2];
    logic [31:0] hwdata    [2];
    wire         hreadyout [2];
    wire  [31:0] hrdata    [2];
    wire         hresp     [2];

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_m   [2][1024];
    logic [31:0] last_rd [2];

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    hasti_sram_slave #(.ADDR_WORDS_LOG2(8), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn[0]), .hsel(hsel[0]), .haddr(haddr[0]),
        .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(3'd0), .hprot(4'd3),
        .htrans(htrans[0]), .hmastlock(1'b0), .hwdata(hwdata[0]), .hready(hreadyout[0]),
        .hreadyout(hreadyout[0]), .hrdata(hrdata[0]), .hresp(hresp[0])
    );

    hasti_sram_slave #(.ADDR_WORDS_LOG2(8), .WAIT_STATES(3)) dut1 (
        .hclk(hclk), .hresetn(hresetn[1]), .hsel(hsel[1]), .haddr(haddr[1]),
        .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(3'd1), .hprot(4'd3),
        .htrans(htrans[1]), .hmastlock(1'b0), .hwdata(hwdata[1]), .hready(hreadyout[1]),
        .hreadyout(hreadyout[1]), .hrdata(hrdata[1]), .hresp(hresp[1])
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wd;
        bit          chk;
        logic [31:0] exp_rd;
        logic        exp_resp;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        if (!ErrMode) return 1'b0;
        if (sz > 3'd2) return 1'b1;
        if (sz == 3'd1) return a[0];
        if (sz == 3'd2) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_word(input int d, input logic [31:0] a);
        int base;
        base = int'(a & 32'h3FC);
        return {mem_m[d][base+3], mem_m[d][base+2], mem_m[d][base+1], mem_m[d][base]};
    endfunction

    task automatic m_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd);
        int base, lo, n;
        base = int'(a & 32'h3FC);
        if (sz == 3'd0) begin
            lo = int'(a & 32'h3); n = 1;
        end else if (sz == 3'd1) begin
            lo = int'(a & 32'h2); n = 2;
        end else begin
            lo = 0; n = 4;
        end
        for (int l = lo; l < lo + n; l++) mem_m[d][base+l] = wd[8*l +: 8];
    endtask

    // One isolated transfer: address phase, then data phase until hreadyout.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic r1,
                        output logic r2, output int waits);
        @(negedge hclk);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
        @(negedge hclk);
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd;
        r1 = hresp[d];
        waits = 0;
        while (hreadyout[d] !== 1'b1 && waits < 16) begin
            waits++;
            @(negedge hclk);
        end
        rd = hrdata[d];
        r2 = hresp[d];
    endtask

    task automatic cx(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rs);
        logic r1, r2;
        int   w;
        bit   e;
        xfer(d, wr, a, sz, wd, rd, r1, r2, w);
        e = is_err(a, sz);
        check($sformatf("d%0d waits @%h", d, a), 32'(w), 32'(e ? 1 : ws_of(d)));
        check($sformatf("d%0d resp_first @%h", d, a), 32'(r1), 32'(e));
        check($sformatf("d%0d resp_end @%h", d, a), 32'(r2), 32'(e));
        if (!wr && !e) last_rd[d] = m_word(d, a);
        check($sformatf("d%0d hrdata @%h", d, a), rd, last_rd[d]);
        if (wr && !e) m_write(d, a, sz, wd);
        rs = r2;
    endtask

    // Write immediately followed by a read accepted on the write's commit edge.
    task automatic fwd(input logic [31:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                       input logic [31:0] ra);
        @(negedge hclk);
        hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = wa; hwrite[0] = 1'b1; hsize[0] = wsz;
        @(negedge hclk);
        check("fwd write data ready", 32'(hreadyout[0]), 32'd1);
        hwdata[0] = wd; haddr[0] = ra; hwrite[0] = 1'b0; hsize[0] = 3'd2;
        @(negedge hclk);
        hsel[0] = 1'b0; htrans[0] = 2'b00;
        m_write(0, wa, wsz, wd);
        last_rd[0] = m_word(0, ra);
        check("fwd read ready", 32'(hreadyout[0]), 32'd1);
        check($sformatf("fwd hrdata @%h", ra), hrdata[0], last_rd[0]);
    endtask

    task automatic fill(input int d);
        logic [31:0] rd;
        logic        rs;
        for (int w = 0; w < 256; w++) cx(d, 1'b1, 32'h2000_0000 + 32'(4 * w), 3'd2, $urandom, rd, rs);
    endtask

    task automatic rand_run(input int d, input int n);
        logic [31:0] rd;
        logic        rs;
        logic [2:0]  sz;
        int          s;
        for (int i = 0; i < n; i++) begin
            s  = $urandom_range(0, 7);
            sz = (s < 3) ? 3'(s) : ((s == 7) ? 3'd3 : 3'd2);
            cx(d, 1'($urandom_range(0, 1)), 32'h2000_0000 | ($urandom & 32'h0000_0FFF), sz,
               $urandom, rd, rs);
        end
    endtask

    initial begin
        logic [31:0] rd, first;
        logic        rs;

        for (int d = 0; d < 2; d++) begin
            hresetn[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; hwrite[d] = 1'b0;
            hsize[d] = '0; htrans[d] = 2'b00; hwdata[d] = '0; last_rd[d] = '0;
        end

        tbl[0]  = '{1'b1, 32'h2000_0010, 3'd2, 32'h1122_3344, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h2000_0013, 3'd0, 32'hAA00_0000, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h2000_0010, 3'd2, 32'h0, 1'b1, 32'hAA22_3344, 1'b0};
        tbl[3]  = '{1'b1, 32'h2000_0014, 3'd1, 32'h0000_BEEF, 1'b0, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 32'h2000_0016, 3'd1, 32'hCAFE_0000, 1'b0, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 32'h2000_0414, 3'd2, 32'h0, 1'b1, 32'hCAFE_BEEF, 1'b0};
        tbl[6]  = '{1'b0, 32'h2000_0011, 3'd0, 32'h0, 1'b1, 32'hAA22_3344, 1'b0};
        tbl[7]  = '{1'b1, 32'h2000_0000, 3'd2, 32'h1234_5678, 1'b0, 32'h0, 1'b0};
        tbl[8]  = '{1'b1, 32'h2000_0002, 3'd2, 32'h9ABC_DEF0, 1'b0, 32'h0, ErrMode};
        tbl[9]  = '{1'b0, 32'h2000_0000, 3'd2, 32'h0, 1'b1,
                    ErrMode ? 32'h1234_5678 : 32'h9ABC_DEF0, 1'b0};
        tbl[10] = '{1'b0, 32'h2000_0001, 3'd2, 32'h0, 1'b1,
                    ErrMode ? 32'h1234_5678 : 32'h9ABC_DEF0, ErrMode};
        tbl[11] = '{1'b0, 32'h2000_0010, 3'd3, 32'h0, 1'b1,
                    ErrMode ? 32'h1234_5678 : 32'hAA22_3344, ErrMode};

        repeat (3) @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            hresetn[d] = 1'b1;
            check($sformatf("d%0d reset hreadyout", d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'd0);
            check($sformatf("d%0d reset hrdata", d), hrdata[d], 32'h0);
        end

        // Selected but IDLE/BUSY: must stay ready with OKAY.
        hsel[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            htrans[0] = (c < 3) ? 2'b00 : 2'b01;
            @(negedge hclk);
            check($sformatf("idle%0d hreadyout", c), 32'(hreadyout[0]), 32'd1);
            check($sformatf("idle%0d hresp", c), 32'(hresp[0]), 32'd0);
        end
        check("idle hrdata", hrdata[0], 32'h0);
        hsel[0] = 1'b0; htrans[0] = 2'b00;

        // ---- WAIT_STATES = 0 ----
        fill(0);
        for (int i = 0; i < 12; i++) begin
            cx(0, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wd, rd, rs);
            if (tbl[i].chk) check($sformatf("tbl%0d rd", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d resp", i), 32'(rs), 32'(tbl[i].exp_resp));
        end

        cx(0, 1'b1, 32'h2000_0022, 3'd2, 32'h5566_7788, rd, rs);
        @(negedge hclk);
        check("after misaligned hresp", 32'(hresp[0]), 32'd0);
        check("after misaligned hreadyout", 32'(hreadyout[0]), 32'd1);
        cx(0, 1'b0, 32'h2000_0020, 3'd2, 32'h0, rd, rs);

        fwd(32'h2000_0010, 3'd2, 32'hDEAD_BEEF, 32'h2000_0010);
        check("fwd deadbeef", last_rd[0], 32'hDEAD_BEEF);
        fwd(32'h2000_0011, 3'd0, 32'h0000_7700, 32'h2000_0010);
        fwd(32'h2000_0030, 3'd2, 32'h0BAD_F00D, 32'h2000_0034);
        cx(0, 1'b0, 32'h2000_0030, 3'd2, 32'h0, rd, rs);

        rand_run(0, 150);

        // ---- WAIT_STATES = 3 ----
        fill(1);
        cx(1, 1'b0, 32'h2000_0048, 3'd2, 32'h0, rd, rs);
        @(negedge hclk);
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h2000_0044; hwrite[1] = 1'b0;
        hsize[1] = 3'd2;
        @(negedge hclk);
        hsel[1] = 1'b0; htrans[1] = 2'b00;
        first = hrdata[1];
        last_rd[1] = m_word(1, 32'h2000_0044);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ws3 cycle%0d hreadyout", k), 32'(hreadyout[1]), (k < 3) ? 32'd0 : 32'd1);
            check($sformatf("ws3 cycle%0d hrdata stable", k), hrdata[1], first);
            if (k < 3) @(negedge hclk);
        end
        check("ws3 read data", hrdata[1], last_rd[1]);

        // Reset during a write's wait state: write abandoned.
        @(negedge hclk);
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h2000_0040; hwrite[1] = 1'b1;
        hsize[1] = 3'd2;
        @(negedge hclk);
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = ~m_word(1, 32'h2000_0040);
        check("rst-wait in wait", 32'(hreadyout[1]), 32'd0);
        #2 hresetn[1] = 1'b0;
        #1;
        check("rst-wait hreadyout async", 32'(hreadyout[1]), 32'd1);
        check("rst-wait hresp", 32'(hresp[1]), 32'd0);
        check("rst-wait hrdata", hrdata[1], 32'h0);
        last_rd[1] = '0;
        @(negedge hclk);
        hresetn[1] = 1'b1;
        cx(1, 1'b0, 32'h2000_0040, 3'd2, 32'h0, rd, rs);

        rand_run(1, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
